// File: rtl/hazard_pkg.sv
// Shared types, default sizes and opcode helpers for the scoreboard hazard unit.
package hazard_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      RAW  = 2'd1,
      WAW  = 2'd2,
      FULL = 2'd3
   } stall_cause_e;

   localparam int DEF_NUM_REGS  = 32;
   localparam int DEF_RW        = 5;
   localparam int DEF_MAX_OUT   = 4;
   localparam int DEF_BYPASS_WB = 0;
   localparam int DEF_CNT_W     = 16;

   localparam logic [6:0] OPC_LW    = 7'b0000011;
   localparam logic [6:0] OPC_ALU   = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // MUL/DIV share the register-register ALU opcode and are told apart by funct7.
   function automatic logic is_long_lat(input logic [6:0] opcode,
                                        input logic [6:0] funct7 = 7'd0);
      return (opcode == OPC_LW) || ((opcode == OPC_ALU) && (funct7 == F7_MULDIV));
   endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode/writeback bus into the hazard unit plus its status outputs.
interface scoreboard_hazard_unit_if
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int RW       = DEF_RW,
   parameter int MAX_OUT  = DEF_MAX_OUT,
   parameter int CNT_W    = DEF_CNT_W
);
   logic                           id_valid;
   logic [RW-1:0]                  id_rs1;
   logic [RW-1:0]                  id_rs2;
   logic                           id_rs1_used;
   logic                           id_rs2_used;
   logic [RW-1:0]                  id_rd;
   logic                           id_rd_we;
   logic                           id_long_lat;
   logic                           flush;
   logic                           wb_valid;
   logic [RW-1:0]                  wb_rd;
   logic                           stall;
   stall_cause_e                   stall_cause;
   logic [NUM_REGS-1:0]            pending_mask;
   logic [$clog2(MAX_OUT+1)-1:0]   outstanding;
   logic [CNT_W-1:0]               stall_cycles;
   logic                           protocol_err;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
             id_long_lat, flush, wb_valid, wb_rd,
      input  stall, stall_cause, pending_mask, outstanding, stall_cycles, protocol_err
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we,
             id_long_lat, flush, wb_valid, wb_rd,
      output stall, stall_cause, pending_mask, outstanding, stall_cycles, protocol_err
   );
endinterface

// File: rtl/scoreboard_hazard_unit_sb_pending_table.sv
// Pending-destination bitmap, in-flight counter and sticky writeback protocol error.
module sb_pending_table
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int RW       = DEF_RW,
   parameter int MAX_OUT  = DEF_MAX_OUT
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         issue,
   input  logic [RW-1:0]                issue_rd,
   input  logic                         wb_valid,
   input  logic [RW-1:0]                wb_rd,
   output logic [NUM_REGS-1:0]          pending,
   output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
   output logic                         protocol_err
);
   localparam int OW = $clog2(MAX_OUT + 1);

   logic                wb_hit;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] set_mask;

   assign wb_hit   = wb_valid && (wb_rd != '0) && pending[wb_rd];
   assign clr_mask = wb_hit ? (NUM_REGS'(1) << wb_rd) : '0;
   assign set_mask = issue ? (NUM_REGS'(1) << issue_rd) : '0;

   // Set is applied after clear so a same-index clear+set leaves the bit pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending      <= '0;
         outstanding  <= '0;
         protocol_err <= 1'b0;
      end else begin
         pending <= (pending & ~clr_mask) | set_mask;
         if (issue && !wb_hit)
            outstanding <= outstanding + OW'(1);
         else if (!issue && wb_hit)
            outstanding <= outstanding - OW'(1);
         if (wb_valid && !wb_hit)
            protocol_err <= 1'b1;
      end
   end
endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ID-stage hazard detection against a scoreboard of in-flight long-latency destinations.
module scoreboard_hazard_unit
   import hazard_pkg::*;
#(
   parameter int NUM_REGS  = DEF_NUM_REGS,
   parameter int RW        = DEF_RW,
   parameter int MAX_OUT   = DEF_MAX_OUT,
   parameter int BYPASS_WB = DEF_BYPASS_WB,
   parameter int CNT_W     = DEF_CNT_W
) (
   input logic                     clk,
   input logic                     reset,
   scoreboard_hazard_unit_if.slave bus
);
   localparam int OW = $clog2(MAX_OUT + 1);

   logic [NUM_REGS-1:0] eff;
   logic                active;
   logic                raw_hz;
   logic                waw_hz;
   logic                full_hz;
   logic                bypass_hit;
   logic                issue;
   logic [OW-1:0]       busy;

   // A same-cycle writeback only counts as resolved when bypassing is enabled.
   always_comb begin
      eff = bus.pending_mask;
      if ((BYPASS_WB != 0) && bus.wb_valid)
         eff[bus.wb_rd] = 1'b0;
   end

   assign active     = bus.id_valid && !bus.flush;
   assign bypass_hit = (BYPASS_WB != 0) && bus.wb_valid && bus.pending_mask[bus.wb_rd];
   assign busy       = bus.outstanding - OW'(bypass_hit);

   assign raw_hz  = active && ((bus.id_rs1_used && (bus.id_rs1 != '0) && eff[bus.id_rs1]) ||
                               (bus.id_rs2_used && (bus.id_rs2 != '0) && eff[bus.id_rs2]));
   assign waw_hz  = active && bus.id_rd_we && (bus.id_rd != '0) && eff[bus.id_rd];
   assign full_hz = active && bus.id_long_lat && bus.id_rd_we && (busy == OW'(MAX_OUT));

   always_comb begin
      bus.stall_cause = NONE;
      if (raw_hz)
         bus.stall_cause = RAW;
      else if (waw_hz)
         bus.stall_cause = WAW;
      else if (full_hz)
         bus.stall_cause = FULL;
   end

   assign bus.stall = raw_hz || waw_hz || full_hz;
   assign issue     = active && !bus.stall && bus.id_long_lat && bus.id_rd_we && (bus.id_rd != '0);

   sb_pending_table #(
      .NUM_REGS (NUM_REGS),
      .RW       (RW),
      .MAX_OUT  (MAX_OUT)
   ) u_table (
      .clk          (clk),
      .reset        (reset),
      .issue        (issue),
      .issue_rd     (bus.id_rd),
      .wb_valid     (bus.wb_valid),
      .wb_rd        (bus.wb_rd),
      .pending      (bus.pending_mask),
      .outstanding  (bus.outstanding),
      .protocol_err (bus.protocol_err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         bus.stall_cycles <= '0;
      else if (bus.stall && (bus.stall_cycles != '1))
         bus.stall_cycles <= bus.stall_cycles + CNT_W'(1);
   end
endmodule
